// File: rtl/exec_wb_tracker_if.sv
// Issue/complete/forward/writeback bundle between decode, exec units and the in-flight result tracker.
// master = issuing side and completion units; slave = tracker.
interface exec_wb_tracker_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    localparam int TW = $clog2(DEPTH);

    logic              issue_valid;
    logic              issue_ready;
    logic              issue_wr;
    logic              issue_fmode;
    logic [REG_W-1:0]  issue_rd;
    logic              issue_imm;
    logic [DATA_W-1:0] issue_data;
    logic [TW-1:0]     issue_tag;

    logic              cmpl_valid;
    logic [TW-1:0]     cmpl_tag;
    logic [DATA_W-1:0] cmpl_data;

    logic [REG_W-1:0]  src1_no;
    logic [REG_W-1:0]  src2_no;
    logic              src1_fmode;
    logic              src2_fmode;
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic [DATA_W-1:0] fwd2_data;
    logic              hazard;

    logic              flush;
    logic              pending_any;

    logic              wb_valid;
    logic              wb_we;
    logic              wb_fmode;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output issue_valid, issue_wr, issue_fmode, issue_rd, issue_imm, issue_data,
        input  issue_ready, issue_tag,
        output cmpl_valid, cmpl_tag, cmpl_data,
        output src1_no, src2_no, src1_fmode, src2_fmode,
        input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, hazard,
        output flush,
        input  pending_any,
        input  wb_valid, wb_we, wb_fmode, wb_rd, wb_data
    );

    modport slave (
        input  issue_valid, issue_wr, issue_fmode, issue_rd, issue_imm, issue_data,
        output issue_ready, issue_tag,
        input  cmpl_valid, cmpl_tag, cmpl_data,
        input  src1_no, src2_no, src1_fmode, src2_fmode,
        output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, hazard,
        input  flush,
        output pending_any,
        output wb_valid, wb_we, wb_fmode, wb_rd, wb_data
    );
endinterface

// File: rtl/exec_wb_tracker.sv
// Age-ordered ring of in-flight exec results: captures, forwards youngest match, retires in order.
// Forwarding/hazard combinational; writeback 1 cycle after head is ready; issue_ready drops at DEPTH.
module exec_wb_tracker #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic               clk,
    input  logic               rstn,
    exec_wb_tracker_if.slave   bus
);
    localparam int TW = $clog2(DEPTH);

    typedef struct packed {
        logic              valid;
        logic              ready;
        logic              wr;
        logic              fmode;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } slot_t;

    slot_t         slots [DEPTH];
    logic [TW-1:0] head;
    logic [TW-1:0] tail;
    logic [TW:0]   count;

    logic          issue_acc;
    logic          retire;
    logic          cmpl_acc;
    logic          m1, m2;
    logic [TW-1:0] i1, i2;
    logic          byp1, byp2;

    // Readiness uses registered count only, so a same-cycle retire never frees the issuing slot.
    assign bus.issue_ready = (count < (TW+1)'(DEPTH));
    assign bus.issue_tag   = tail;
    assign issue_acc       = bus.issue_valid & bus.issue_ready;
    assign retire          = slots[head].valid & slots[head].ready;
    assign cmpl_acc        = bus.cmpl_valid & slots[bus.cmpl_tag].valid & ~slots[bus.cmpl_tag].ready;

    // Int r0 is hardwired zero and is never supplied by the tracker.
    function automatic logic src_match(slot_t s, logic [REG_W-1:0] no, logic fm);
        return s.valid && s.wr && (s.fmode == fm) && (s.rd == no) && (fm || (no != '0));
    endfunction

    // Walk from oldest to youngest so the last match found is the youngest writer.
    always_comb begin
        m1 = 1'b0;
        m2 = 1'b0;
        i1 = '0;
        i2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (src_match(slots[head + TW'(i)], bus.src1_no, bus.src1_fmode)) begin
                m1 = 1'b1;
                i1 = head + TW'(i);
            end
            if (src_match(slots[head + TW'(i)], bus.src2_no, bus.src2_fmode)) begin
                m2 = 1'b1;
                i2 = head + TW'(i);
            end
        end
    end

    assign byp1 = bus.cmpl_valid && (bus.cmpl_tag == i1);
    assign byp2 = bus.cmpl_valid && (bus.cmpl_tag == i2);

    assign bus.fwd1_hit  = m1 && (slots[i1].ready || byp1);
    assign bus.fwd2_hit  = m2 && (slots[i2].ready || byp2);
    assign bus.fwd1_data = !bus.fwd1_hit ? '0 : (slots[i1].ready ? slots[i1].data : bus.cmpl_data);
    assign bus.fwd2_data = !bus.fwd2_hit ? '0 : (slots[i2].ready ? slots[i2].data : bus.cmpl_data);
    assign bus.hazard    = (m1 && !bus.fwd1_hit) || (m2 && !bus.fwd2_hit);

    always_comb begin
        bus.pending_any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slots[i].valid && !slots[i].ready) bus.pending_any = 1'b1;
        end
    end

    // Issue, completion and retire never touch the same slot in one cycle, so their writes are disjoint.
    always_ff @(posedge clk) begin
        if (!rstn || bus.flush) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            bus.wb_valid <= 1'b0;
            if (!rstn) begin
                bus.wb_we    <= 1'b0;
                bus.wb_fmode <= 1'b0;
                bus.wb_rd    <= '0;
                bus.wb_data  <= '0;
            end
        end else begin
            if (cmpl_acc) begin
                slots[bus.cmpl_tag].ready <= 1'b1;
                slots[bus.cmpl_tag].data  <= bus.cmpl_data;
            end
            if (issue_acc) begin
                slots[tail] <= '{valid: 1'b1, ready: bus.issue_imm, wr: bus.issue_wr,
                                 fmode: bus.issue_fmode, rd: bus.issue_rd, data: bus.issue_data};
                tail        <= tail + 1'b1;
            end
            bus.wb_valid <= retire;
            if (retire) begin
                slots[head].valid <= 1'b0;
                slots[head].ready <= 1'b0;
                head              <= head + 1'b1;
                bus.wb_we         <= slots[head].wr;
                bus.wb_fmode      <= slots[head].fmode;
                bus.wb_rd         <= slots[head].rd;
                bus.wb_data       <= slots[head].data;
            end
            count <= count + (TW+1)'(issue_acc) - (TW+1)'(retire);
        end
    end
endmodule

// File: tb/tb_exec_wb_tracker.sv
// Directed bench for exec_wb_tracker: inputs change 1 unit after the rising edge, outputs are checked 2 units later.
// Each step is one clock cycle; expected values are hand-derived from the tracker behaviour.
module tb_exec_wb_tracker;
    logic clk = 1'b0;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    exec_wb_tracker_if #(.DEPTH(4), .DATA_W(32), .REG_W(5)) bus ();

    exec_wb_tracker #(.DEPTH(4), .DATA_W(32), .REG_W(5)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] exp_wb [10] = '{32'h101, 32'h102, 32'h103, 32'h104,
                                 32'h200, 32'h201, 32'h202, 32'h203, 32'h204, 32'h205};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
        bus.cmpl_valid  = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic issue(input logic wr, input logic fm, input logic [4:0] rd,
                         input logic imm, input logic [31:0] d);
        bus.issue_valid = 1'b1;
        bus.issue_wr    = wr;
        bus.issue_fmode = fm;
        bus.issue_rd    = rd;
        bus.issue_imm   = imm;
        bus.issue_data  = d;
    endtask

    task automatic cmpl(input logic [1:0] tag, input logic [31:0] d);
        bus.cmpl_valid = 1'b1;
        bus.cmpl_tag   = tag;
        bus.cmpl_data  = d;
    endtask

    task automatic src(input logic [4:0] n1, input logic f1, input logic [4:0] n2, input logic f2);
        bus.src1_no    = n1;
        bus.src1_fmode = f1;
        bus.src2_no    = n2;
        bus.src2_fmode = f2;
    endtask

    initial begin
        rstn = 1'b0;
        bus.issue_valid = 1'b0; bus.issue_wr = 1'b0; bus.issue_fmode = 1'b0; bus.issue_rd = '0;
        bus.issue_imm = 1'b0; bus.issue_data = '0;
        bus.cmpl_valid = 1'b0; bus.cmpl_tag = '0; bus.cmpl_data = '0;
        bus.flush = 1'b0;
        src(5'd0, 1'b0, 5'd0, 1'b0);

        // Reset state
        cyc(); cyc(); look();
        chk("rst_wb_valid", 32'(bus.wb_valid), 0);
        chk("rst_wb_we", 32'(bus.wb_we), 0);
        chk("rst_wb_fmode", 32'(bus.wb_fmode), 0);
        chk("rst_wb_rd", 32'(bus.wb_rd), 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_issue_ready", 32'(bus.issue_ready), 1);
        chk("rst_issue_tag", 32'(bus.issue_tag), 0);
        chk("rst_pending", 32'(bus.pending_any), 0);
        chk("rst_hazard", 32'(bus.hazard), 0);
        cyc(); rstn = 1'b1;

        // Two immediate writers of int r3: youngest forwards, retire in order
        cyc(); issue(1, 0, 5'd3, 1, 32'h11); src(5'd3, 0, 5'd0, 0); look();
        chk("t1_tag0", 32'(bus.issue_tag), 0);
        chk("t1_fwd_empty", 32'(bus.fwd1_hit), 0);
        cyc(); issue(1, 0, 5'd3, 1, 32'h22); look();
        chk("t1_tag1", 32'(bus.issue_tag), 1);
        chk("t1_fwd_old_hit", 32'(bus.fwd1_hit), 1);
        chk("t1_fwd_old_data", bus.fwd1_data, 32'h11);
        cyc(); look();
        chk("t1_fwd_young_hit", 32'(bus.fwd1_hit), 1);
        chk("t1_fwd_young_data", bus.fwd1_data, 32'h22);
        chk("t1_wb0_valid", 32'(bus.wb_valid), 1);
        chk("t1_wb0_data", bus.wb_data, 32'h11);
        chk("t1_wb0_rd", 32'(bus.wb_rd), 3);
        chk("t1_wb0_we", 32'(bus.wb_we), 1);
        chk("t1_wb0_fmode", 32'(bus.wb_fmode), 0);
        cyc(); look();
        chk("t1_wb1_valid", 32'(bus.wb_valid), 1);
        chk("t1_wb1_data", bus.wb_data, 32'h22);
        cyc(); look();
        chk("t1_idle_wb", 32'(bus.wb_valid), 0);
        chk("t1_idle_fwd", 32'(bus.fwd1_hit), 0);

        // Pending float f5: hazard, then same-cycle completion bypass
        cyc(); bus.flush = 1'b1; look();
        cyc(); issue(1, 1, 5'd5, 0, 32'h0); src(5'd3, 0, 5'd5, 1); look();
        chk("t2_tag0", 32'(bus.issue_tag), 0);
        chk("t2_hz_before", 32'(bus.hazard), 0);
        cyc(); look();
        chk("t2_pending", 32'(bus.pending_any), 1);
        chk("t2_hazard", 32'(bus.hazard), 1);
        chk("t2_nohit", 32'(bus.fwd2_hit), 0);
        cyc(); cmpl(2'd0, 32'h3F800000); look();
        chk("t2_byp_hit", 32'(bus.fwd2_hit), 1);
        chk("t2_byp_data", bus.fwd2_data, 32'h3F800000);
        chk("t2_byp_hazard", 32'(bus.hazard), 0);
        cyc(); look();
        chk("t2_wb_not_yet", 32'(bus.wb_valid), 0);
        chk("t2_pending_clr", 32'(bus.pending_any), 0);
        chk("t2_rdy_hit", 32'(bus.fwd2_hit), 1);
        cyc(); look();
        chk("t2_wb_valid", 32'(bus.wb_valid), 1);
        chk("t2_wb_fmode", 32'(bus.wb_fmode), 1);
        chk("t2_wb_rd", 32'(bus.wb_rd), 5);
        chk("t2_wb_data", bus.wb_data, 32'h3F800000);

        // Pending op blocks a younger ready op from retiring
        cyc(); bus.flush = 1'b1; src(5'd3, 0, 5'd7, 1); look();
        cyc(); issue(1, 0, 5'd7, 0, 32'h0); look();
        chk("t3_tag0", 32'(bus.issue_tag), 0);
        chk("t3_wb_flushed", 32'(bus.wb_valid), 0);
        cyc(); issue(1, 0, 5'd7, 1, 32'h77); look();
        chk("t3_tag1", 32'(bus.issue_tag), 1);
        cyc(); src(5'd7, 0, 5'd7, 1); look();
        chk("t3_young_hit", 32'(bus.fwd1_hit), 1);
        chk("t3_young_data", bus.fwd1_data, 32'h77);
        chk("t3_young_hazard", 32'(bus.hazard), 0);
        chk("t3_float_nohit", 32'(bus.fwd2_hit), 0);
        chk("t3_wb_a", 32'(bus.wb_valid), 0);
        cyc(); look();
        chk("t3_wb_b", 32'(bus.wb_valid), 0);
        cyc(); cmpl(2'd0, 32'h70); look();
        chk("t3_wb_c", 32'(bus.wb_valid), 0);
        cyc(); look();
        chk("t3_wb_d", 32'(bus.wb_valid), 0);
        cyc(); look();
        chk("t3_wb0_valid", 32'(bus.wb_valid), 1);
        chk("t3_wb0_data", bus.wb_data, 32'h70);
        cyc(); look();
        chk("t3_wb1_valid", 32'(bus.wb_valid), 1);
        chk("t3_wb1_data", bus.wb_data, 32'h77);

        // Int r0 never forwards; int and float r4 are distinct
        cyc(); issue(1, 0, 5'd0, 1, 32'h5); src(5'd0, 0, 5'd7, 1); look();
        chk("t4_wb_idle", 32'(bus.wb_valid), 0);
        cyc(); issue(1, 0, 5'd4, 1, 32'h44); look();
        chk("t4_r0_nohit", 32'(bus.fwd1_hit), 0);
        chk("t4_r0_nohz", 32'(bus.hazard), 0);
        cyc(); src(5'd4, 0, 5'd4, 1); look();
        chk("t4_int4_hit", 32'(bus.fwd1_hit), 1);
        chk("t4_int4_data", bus.fwd1_data, 32'h44);
        chk("t4_flt4_nohit", 32'(bus.fwd2_hit), 0);
        chk("t4_wb_r0_valid", 32'(bus.wb_valid), 1);
        chk("t4_wb_r0_rd", 32'(bus.wb_rd), 0);
        chk("t4_wb_r0_data", bus.wb_data, 32'h5);
        cyc(); look();
        chk("t4_wb_r4_rd", 32'(bus.wb_rd), 4);
        chk("t4_wb_r4_data", bus.wb_data, 32'h44);

        // Fill all slots pending, reject extra issue, complete out of order, then wrap
        cyc(); bus.flush = 1'b1; src(5'd9, 0, 5'd9, 0); look();
        for (int k = 0; k < 4; k++) begin
            cyc(); issue(1, 0, 5'(k + 1), 0, 32'h0); look();
            chk("t5_fill_tag", 32'(bus.issue_tag), 32'(k));
            chk("t5_fill_ready", 32'(bus.issue_ready), 1);
        end
        cyc(); issue(1, 0, 5'd9, 1, 32'hBAD); look();
        chk("t5_full_ready", 32'(bus.issue_ready), 0);
        chk("t5_full_tag", 32'(bus.issue_tag), 0);
        chk("t5_full_pending", 32'(bus.pending_any), 1);
        cyc(); cmpl(2'd3, 32'h104); look();
        chk("t5_ignored_ready", 32'(bus.issue_ready), 0);
        chk("t5_ignored_tag", 32'(bus.issue_tag), 0);
        chk("t5_ignored_fwd", 32'(bus.fwd1_hit), 0);
        cyc(); cmpl(2'd1, 32'h102); look();
        chk("t5_wb_wait_a", 32'(bus.wb_valid), 0);
        cyc(); cmpl(2'd2, 32'h103); look();
        cyc(); cmpl(2'd0, 32'h101); look();
        chk("t5_wb_wait_b", 32'(bus.wb_valid), 0);
        cyc(); cmpl(2'd3, 32'hDEAD); look();
        chk("t5_wb_wait_c", 32'(bus.wb_valid), 0);
        chk("t5_all_done", 32'(bus.pending_any), 0);
        for (int j = 0; j < 10; j++) begin
            cyc();
            if (j < 6) issue(1, 0, 5'(10 + j), 1, 32'h200 + 32'(j));
            look();
            if (j < 6) chk("t5_wrap_tag", 32'(bus.issue_tag), 32'(j % 4));
            chk("t5_wb_valid", 32'(bus.wb_valid), 1);
            chk("t5_wb_data", bus.wb_data, exp_wb[j]);
        end
        cyc(); look();
        chk("t5_drained_wb", 32'(bus.wb_valid), 0);
        chk("t5_drained_pend", 32'(bus.pending_any), 0);

        // Flush with three ready slots
        cyc(); issue(1, 0, 5'd20, 0, 32'h0); src(5'd21, 0, 5'd9, 0); look();
        chk("t6_tag_p", 32'(bus.issue_tag), 2);
        cyc(); issue(1, 0, 5'd21, 1, 32'h301); look();
        cyc(); issue(1, 0, 5'd22, 1, 32'h302); look();
        chk("t6_blocked_wb", 32'(bus.wb_valid), 0);
        chk("t6_fwd21_hit", 32'(bus.fwd1_hit), 1);
        cyc(); cmpl(2'd2, 32'h300); look();
        chk("t6_pending", 32'(bus.pending_any), 1);
        cyc(); bus.flush = 1'b1; look();
        chk("t6_pre_pending", 32'(bus.pending_any), 0);
        chk("t6_pre_wb", 32'(bus.wb_valid), 0);
        chk("t6_pre_fwd_data", bus.fwd1_data, 32'h301);
        cyc(); look();
        chk("t6_post_wb", 32'(bus.wb_valid), 0);
        chk("t6_post_tag", 32'(bus.issue_tag), 0);
        chk("t6_post_ready", 32'(bus.issue_ready), 1);
        chk("t6_post_fwd", 32'(bus.fwd1_hit), 0);
        chk("t6_post_pend", 32'(bus.pending_any), 0);

        // Reset mid-run; late completion is ignored
        cyc(); issue(1, 0, 5'd6, 1, 32'h66); look();
        cyc(); issue(1, 0, 5'd7, 0, 32'h0); look();
        chk("t7_tag1", 32'(bus.issue_tag), 1);
        cyc(); rstn = 1'b0; look();
        chk("t7_wb_valid", 32'(bus.wb_valid), 1);
        chk("t7_wb_data", bus.wb_data, 32'h66);
        chk("t7_pending", 32'(bus.pending_any), 1);
        cyc(); look();
        chk("t7_rst_wb_valid", 32'(bus.wb_valid), 0);
        chk("t7_rst_wb_we", 32'(bus.wb_we), 0);
        chk("t7_rst_wb_rd", 32'(bus.wb_rd), 0);
        chk("t7_rst_wb_data", bus.wb_data, 0);
        chk("t7_rst_tag", 32'(bus.issue_tag), 0);
        chk("t7_rst_pending", 32'(bus.pending_any), 0);
        chk("t7_rst_ready", 32'(bus.issue_ready), 1);
        cyc(); rstn = 1'b1; cmpl(2'd1, 32'h99); src(5'd7, 0, 5'd9, 0); look();
        chk("t7_late_fwd", 32'(bus.fwd1_hit), 0);
        chk("t7_late_hazard", 32'(bus.hazard), 0);
        cyc(); look();
        chk("t7_late_pending", 32'(bus.pending_any), 0);
        chk("t7_late_wb_a", 32'(bus.wb_valid), 0);
        cyc(); look();
        chk("t7_late_wb_b", 32'(bus.wb_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
